// File: rtl/seq_div_pkg.sv
// seq_div_pkg: FSM state encoding and sizing helper shared by the
// seq_div_nb restoring divider.
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter width for a given operand width.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/rcs_nb.sv
// rcs_nb: N-bit ripple-borrow subtractor, diff = a - b, bout set
// when b > a.
module rcs_nb #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         bout
);

    logic [N:0] w_brw;

    assign w_brw[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign diff[i]    = a[i] ^ b[i] ^ w_brw[i];
        assign w_brw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_brw[i]);
    end

    assign bout = w_brw[N];

endmodule

// File: rtl/seq_div_nb.sv
// seq_div_nb: sequential restoring divider, one quotient bit per cycle.
// Optional abort input enabled by defining SEQ_DIV_ABORT_EN.
module seq_div_nb
    import seq_div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz
`ifdef SEQ_DIV_ABORT_EN
    ,
    input  logic             abort
`endif
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH:0]   r_prem;
    logic [WIDTH-1:0] r_dsr;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_dbz;

    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_prem_nx;
    logic [WIDTH-1:0] w_q_nx;
    logic             w_bout;
    logic             w_last;
    logic             w_abort;
    logic             w_unused;

    assign w_trial = {r_prem[WIDTH-1:0], r_dsr[WIDTH-1]};

    rcs_nb #(.N(WIDTH + 1)) u_rcs (
        .a    (w_trial),
        .b    ({1'b0, r_dvs}),
        .diff (w_diff),
        .bout (w_bout)
    );

    // A borrow means the trial failed: keep the shifted remainder.
    assign w_prem_nx = w_bout ? w_trial : w_diff;
    assign w_q_nx    = {r_q[WIDTH-2:0], ~w_bout};
    assign w_last    = (r_cnt == LAST);
    assign w_unused  = r_prem[WIDTH];

`ifdef SEQ_DIV_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_next = (divisor == '0) ? DONE : CALC;
            end
            CALC: begin
                if (w_abort)     w_next = IDLE;
                else if (w_last) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != IDLE);
        done = (r_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prem <= '0;
            r_dsr  <= '0;
            r_dvs  <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && divisor == '0) begin
                        r_quot <= '1;
                        r_rem  <= dividend;
                        r_dbz  <= 1'b1;
                    end else if (start) begin
                        r_dvs  <= divisor;
                        r_dsr  <= dividend;
                        r_prem <= '0;
                        r_q    <= '0;
                        r_cnt  <= '0;
                    end
                end
                CALC: begin
                    if (!w_abort) begin
                        r_prem <= w_prem_nx;
                        r_q    <= w_q_nx;
                        r_dsr  <= {r_dsr[WIDTH-2:0], 1'b0};
                        r_cnt  <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_quot <= w_q_nx;
                            r_rem  <= w_prem_nx[WIDTH-1:0];
                            r_dbz  <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign dbz       = r_dbz;

endmodule

// File: tb/tb_seq_div_nb.sv
// tb_seq_div_nb: table vectors, handshake corner sequences and random
// operands against an arithmetic reference for seq_div_nb (WIDTH=4).
module tb_seq_div_nb;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         dbz;
`ifdef SEQ_DIV_ABORT_EN
    logic         abort = 1'b0;
`endif

    seq_div_nb #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
`ifdef SEQ_DIV_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int z;
    } vec_t;

    vec_t tbl[6];
    int   n_run  = 0;
    int   n_fail = 0;
    int   prev_q = 0;
    int   prev_r = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model(input int a, input int b,
                         output int q, output int r, output int z);
        if (b == 0) begin
            q = (1 << W) - 1;
            r = a;
            z = 1;
        end else begin
            q = a / b;
            r = a % b;
            z = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string nm, input int n0, input int lat);
        int n;
        n = n0;
        while (!done && n < W + 4) begin
            tick();
            n++;
        end
        chk({nm, " done"}, int'(done), 1);
        chk({nm, " latency"}, n, lat);
    endtask

    task automatic check_res(input string nm, input int q, input int r, input int z);
        chk({nm, " quotient"}, int'(quotient), q);
        chk({nm, " remainder"}, int'(remainder), r);
        chk({nm, " dbz"}, int'(dbz), z);
        prev_q = q;
        prev_r = r;
    endtask

    task automatic run_op(input string nm, input int a, input int b,
                          input int q, input int r, input int z);
        dividend = W'(a);
        divisor  = W'(b);
        start    = 1'b1;
        tick();
        start = 1'b0;
        if (b != 0) begin
            chk({nm, " busy"}, int'(busy), 1);
            chk({nm, " hold_q"}, int'(quotient), prev_q);
            chk({nm, " hold_r"}, int'(remainder), prev_r);
        end
        wait_done(nm, 0, (b == 0) ? 0 : W);
        check_res(nm, q, r, z);
        tick();
        chk({nm, " pulse"}, int'(done), 0);
        chk({nm, " idle"}, int'(busy), 0);
    endtask

    task automatic quiet(input string nm);
        int cnt;
        cnt = 0;
        repeat (8) begin
            tick();
            if (done) cnt++;
        end
        chk({nm, " no_done"}, cnt, 0);
        chk({nm, " idle"}, int'(busy), 0);
    endtask

    initial begin
        int q, r, z, a, b;

        tbl[0] = '{13, 4, 3, 1, 0};
        tbl[1] = '{15, 1, 15, 0, 0};
        tbl[2] = '{7, 9, 0, 7, 0};
        tbl[3] = '{0, 5, 0, 0, 0};
        tbl[4] = '{9, 0, 15, 9, 1};
        tbl[5] = '{8, 3, 2, 2, 0};

        repeat (3) tick();
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst quotient", int'(quotient), 0);
        chk("rst remainder", int'(remainder), 0);
        chk("rst dbz", int'(dbz), 0);
        rst = 1'b0;
        tick();
        chk("post_rst busy", int'(busy), 0);

        for (int i = 0; i < 6; i++)
            run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b,
                   tbl[i].q, tbl[i].r, tbl[i].z);

        // start re-asserted during CALC is ignored, then taken from IDLE
        dividend = 4'd12;
        divisor  = 4'd5;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        dividend = 4'd6;
        divisor  = 4'd2;
        start    = 1'b1;
        wait_done("ign", 1, W);
        check_res("ign", 2, 2, 0);
        tick();
        chk("ign done_cycle_not_taken", int'(busy), 0);
        tick();
        chk("ign accepted_in_idle", int'(busy), 1);
        start = 1'b0;
        wait_done("ign2", 0, W);
        check_res("ign2", 3, 0, 0);
        tick();

        // synchronous reset in the middle of a calculation
        dividend = 4'd14;
        divisor  = 4'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("midrst busy", int'(busy), 0);
        chk("midrst done", int'(done), 0);
        chk("midrst quotient", int'(quotient), 0);
        chk("midrst remainder", int'(remainder), 0);
        chk("midrst dbz", int'(dbz), 0);
        rst = 1'b0;
        prev_q = 0;
        prev_r = 0;
        quiet("midrst");
        run_op("redo", 14, 3, 4, 2, 0);

`ifdef SEQ_DIV_ABORT_EN
        run_op("pre_abort", 10, 3, 3, 1, 0);
        dividend = 4'd11;
        divisor  = 4'd2;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort busy", int'(busy), 0);
        quiet("abort");
        chk("abort quotient", int'(quotient), 3);
        chk("abort remainder", int'(remainder), 1);
        chk("abort dbz", int'(dbz), 0);
`endif

        for (int i = 0; i < 150; i++) begin
            a = int'($urandom_range(0, (1 << W) - 1));
            b = int'($urandom_range(0, (1 << W) - 1));
            if (i % 10 == 0) b = 0;
            model(a, b, q, r, z);
            run_op($sformatf("rnd%0d_%0d/%0d", i, a, b), a, b, q, r, z);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_div_nb.md
Name: seq_div_nb

Overview:
- Sequential restoring divider: unsigned WIDTH-bit dividend / WIDTH-bit divisor.
- One quotient bit per cycle, produced by repeated trial subtraction through a single ripple-borrow subtractor.
- The FSM sequences the subtractor; start/done handshake toward the host datapath.
- Sits beside the combinational arithmetic blocks as their first multi-cycle consumer.

Parameters:
- WIDTH, 4, operand/quotient/remainder width in bits (>=2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only in IDLE.
- dividend  in  WIDTH  numerator; sampled on the accepting edge.
- divisor  in  WIDTH  denominator; sampled on the accepting edge.
- busy  out  1  high in CALC and DONE.
- done  out  1  one-cycle pulse; results valid.
- quotient  out  WIDTH  registered result.
- remainder  out  WIDTH  registered result.
- dbz  out  1  divide-by-zero flag for the last operation.
- abort  in  1  present only with SEQ_DIV_ABORT_EN.

Behaviour:
- Reset: state IDLE; busy=0, done=0, quotient=0, remainder=0, dbz=0; internal counter and working registers cleared.
- States: IDLE, CALC, DONE.
- IDLE -> CALC: start=1 and divisor!=0.
  - Latch divisor and dividend into the shift register.
  - Clear partial remainder (WIDTH+1 bits) and iteration counter.
- IDLE -> DONE: start=1 and divisor==0 (divide-by-zero path).
- CALC, each cycle:
  - trial = {partial_rem[WIDTH-1:0], dividend_sr MSB} - {1'b0, divisor}, a (WIDTH+1)-bit subtraction.
  - borrow-out=0: partial_rem <= difference, shift 1 into quotient LSB.
  - borrow-out=1: partial_rem <= shifted value, shift 0 into quotient LSB.
  - Dividend shift register shifts left each cycle.
  - Counter increments; after exactly WIDTH iterations -> DONE.
- DONE, lasting one cycle:
  - done=1; quotient/remainder output registers were loaded on DONE entry.
  - Next state IDLE.
- Latency:
  - start sampled at edge k; CALC occupies cycles k+1..k+WIDTH; done=1 during cycle k+WIDTH+1.
  - Divide-by-zero: done=1 during cycle k+1.
- Divide-by-zero results: quotient = all ones, remainder = dividend, dbz=1. dbz is cleared on the next non-zero-divisor completion.
- Output registers are held from DONE until the next DONE; they are not disturbed during a new calculation.
- Ignored requests: start while busy=1 is ignored (no queueing). Operand changes after acceptance have no effect.
- Back-to-back: start may be high in the cycle done=1. It is not accepted there (state DONE); it is accepted in the following IDLE cycle if still high.
- Reset mid-operation: returns to IDLE and clears all outputs on that edge; rst has priority over start/abort.
- Invariant: remainder < divisor whenever dbz=0.

Optional Feature:
- Macro SEQ_DIV_ABORT_EN.
- Defined:
  - abort port exists.
  - abort=1 in CALC -> IDLE next edge; no done pulse; quotient/remainder/dbz outputs keep their previous values.
  - abort in IDLE or DONE has no effect; abort has priority over normal CALC progress.
- Undefined: no abort port; every accepted operation always completes.

Decomposition:
- Shared package seq_div_pkg:
  - state encoding typedef (IDLE=2'd0, CALC=2'd1, DONE=2'd2);
  - counter width constant $clog2(WIDTH+1).
- One sub-module: rcs_nb.
  - Parameterised ripple-borrow subtractor (WIDTH+1 bits).
  - Outputs diff and bout; instantiated once for the trial subtraction.
  - The FSM, shift registers and counter stay in seq_div_nb.

Test Plan (WIDTH=4):
- dividend=13, divisor=4, start pulsed at edge k -> busy=1 from k+1; done=1 only in cycle k+5; quotient=3, remainder=1, dbz=0.
- 15/1 -> quotient=15, remainder=0. 7/9 -> quotient=0, remainder=7. 0/5 -> quotient=0, remainder=0. All done at k+5.
- 9/0 -> done in cycle k+1; quotient=15, remainder=9, dbz=1. A following 8/3 -> quotient=2, remainder=2, dbz=0.
- Start 12/5, then re-assert start with 6/2 during CALC -> ignored; result quotient=2, remainder=2. 6/2 is accepted only once IDLE is reached with start still high.
- rst=1 at k+2 of a 14/3 operation -> next cycle busy=0, done=0, outputs 0; no done pulse follows. A new start of 14/3 then gives quotient=4, remainder=2.
- With SEQ_DIV_ABORT_EN: complete 10/3 (quotient 3, remainder 1), start 11/2, abort=1 at k+3 -> IDLE, no done; quotient=3, remainder=1 retained.
